cnn_host_ctrl: RTL
==================

# cnn_host_ctrl

Host-side controller at the far end of the CNN accelerator's BRAM interface. It writes the input image into the IF BRAM from a byte stream, pulses the accelerator `start`, and waits for `done`. It then reads the result region of the TEMP BRAM and returns it as a byte stream. Weight BRAM contents are preloaded and are not touched by this block.

## Interface
Parameters:
- IMG_LEN, 1024: input image bytes written to IF BRAM per run.
- RES_LEN, 294: result bytes read from TEMP BRAM per run.
- ADDR_W, 32: BRAM byte-address width.
- IF_BASE, 0: byte address of the first IF word.
- RES_BASE, 0: byte address of the first TEMP result word.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset: asynchronous, active-high.
- in_valid  in  1  input byte valid.
- in_data  in  8  input image byte.
- in_ready  out  1  input byte accepted when in_valid & in_ready.
- out_valid  out  1  result byte valid.
- out_data  out  8  result byte.
- out_last  out  1  high with the final result byte.
- out_ready  in  1  downstream accepts.
- cnn_start  out  1  one-cycle start pulse to the accelerator.
- cnn_done  in  1  accelerator done (pulse or level).
- busy  out  1  high in every state except LOAD with zero bytes accepted.
- BRAM_IF_ADDR / BRAM_IF_DIN / BRAM_IF_WE / BRAM_IF_EN  out  ADDR_W / 32 / 4 / 1  IF BRAM write port.
- BRAM_TEMP_ADDR / BRAM_TEMP_WE / BRAM_TEMP_EN  out  ADDR_W / 4 / 1  TEMP BRAM read port (WE is always 0).
- BRAM_TEMP_DOUT  in  32  TEMP read data.

## Operation
- States: LOAD (reset state), KICK, WAIT, RD_REQ, RD_CAP, EMIT.
- LOAD:
  - in_ready=1.
  - Accepted bytes are packed little-endian: byte k of a word goes to DIN[8k+7:8k] and sets WE bit k.
  - On the 4th byte of a word, or on byte IMG_LEN, one write is issued.
  - Write address is IF_BASE + 4·word_index.
  - A final partial word writes only the bytes present (e.g. IMG_LEN%4=2 gives WE=4'b0011).
  - After byte IMG_LEN the block moves to KICK.
- KICK: cnn_start=1 for exactly one cycle, then WAIT.
- WAIT: sample cnn_done. While in WAIT, cnn_done=1 moves the block to RD_REQ. cnn_done in any other state is ignored.
- RD_REQ: BRAM_TEMP_EN=1, WE=0, ADDR=RES_BASE + 4·word_index.
- RD_CAP: capture BRAM_TEMP_DOUT into the unpack register.
- EMIT:
  - Present bytes 0..3 in ascending order, one per out handshake.
  - The last word emits RES_LEN − 4·(words−1) bytes (2 when RES_LEN=294; 74 words total).
  - out_last=1 on byte RES_LEN.
  - After the final handshake, clear all counters and go to LOAD. Otherwise go to RD_REQ for the next word.
- in_ready=0 outside LOAD; bytes offered then are not consumed.
- out_valid=0 outside EMIT. out_data/out_last hold while out_valid=1 & out_ready=0.

## Timing
- Reset values: every output is 0, state is LOAD, all counters are 0. The reset register values of BRAM_*_ADDR are IF_BASE/RES_BASE.
- Reset mid-run: state is LOAD within the same edge. Any pending IF write or TEMP read is dropped, with no partial strobe afterwards.
- Write: the byte handshake completing a word at cycle t produces BRAM_IF_EN=1 with ADDR/DIN/WE at t+1, for exactly one cycle.
- Start: the last byte is accepted at t, the IF write happens at t+1, and cnn_start=1 at t+2.
- Read: cnn_done=1 sampled at d gives:
  - RD_REQ strobe at d+1;
  - DOUT captured at d+2, with 1-cycle BRAM read latency;
  - out_valid=1 at d+3.
- Next word: the last byte handshake of a word at e gives the next RD_REQ at e+1.
- Minimum throughput: 4 bytes per 6 cycles. Input runs at 1 byte/cycle with no bubbles in LOAD.
- Counters: byte counters use $clog2(LEN+1) bits. Word address arithmetic is modulo 2^ADDR_W.

## Structure
- Shared package cnn_host_pkg: state encodings and BYTES_PER_WORD=4.
- One sub-module, cnn_host_unpack:
  - 32-bit capture register and byte-index counter;
  - parameterized valid-byte count;
  - valid/ready byte output with last flag.
- Packing and the FSM live in the top module.

## Test plan
- IMG_LEN=8, bytes 01..08 back-to-back:
  - IF writes at addr 0 (DIN 04030201, WE F) and addr 4 (DIN 08070605, WE F);
  - cnn_start one cycle, exactly 2 cycles after the last byte.
- IMG_LEN=6: second write is DIN 0000_0605, WE 4'b0011, addr 4.
- RES_LEN=294:
  - TEMP model holds word i = {4 copies of i[7:0]};
  - cnn_done pulse gives 294 out bytes, byte n = n/4;
  - out_last only on byte 294;
  - first out_valid 3 cycles after cnn_done.
- out_ready toggled randomly:
  - out_data stable while stalled;
  - no byte lost or duplicated;
  - in_ready=0 throughout the read phase.
- Assert rst during WAIT and during EMIT:
  - all outputs 0 the same cycle;
  - a fresh IMG_LEN load afterwards writes from IF_BASE.
- cnn_done held high during LOAD: ignored; cnn_start and the read sequence occur only after the load completes.

Source files
------------

// File: rtl/cnn_host_pkg.sv
// Shared definitions for the CNN host controller: FSM states, word geometry
// and the helpers that split a byte length into whole and trailing words.
package cnn_host_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        LOAD,
        KICK,
        WAIT,
        RD_REQ,
        RD_CAP,
        EMIT
    } state_t;

    function automatic int word_count(input int len);
        return (len + BYTES_PER_WORD - 1) / BYTES_PER_WORD;
    endfunction

    // Bytes carried by the final (possibly partial) word of a len-byte block.
    function automatic int tail_bytes(input int len);
        return len - BYTES_PER_WORD * (word_count(len) - 1);
    endfunction

endpackage

// File: rtl/cnn_host_unpack.sv
// Holds one TEMP word and streams its bytes out LSB first over valid/ready,
// flagging the final byte of the final word.
module cnn_host_unpack
    import cnn_host_pkg::*;
#(
    parameter int LAST_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cap,
    input  logic        cap_last,
    input  logic [31:0] din,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        word_done
);

    logic [31:0] word_q;
    logic [1:0]  idx;
    logic        last_word;
    logic [1:0]  final_idx;
    logic [1:0]  nxt_idx;

    assign final_idx = last_word ? 2'(LAST_BYTES - 1) : 2'(BYTES_PER_WORD - 1);
    assign nxt_idx   = idx + 2'd1;
    assign word_done = out_valid && out_ready && (idx == final_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q    <= '0;
            idx       <= '0;
            last_word <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (cap) begin
            word_q    <= din;
            idx       <= '0;
            last_word <= cap_last;
            out_valid <= 1'b1;
            out_data  <= din[7:0];
            out_last  <= cap_last && (LAST_BYTES == 1);
        end else if (out_valid && out_ready) begin
            if (idx == final_idx) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                idx      <= nxt_idx;
                out_data <= word_q[{nxt_idx, 3'b000} +: 8];
                out_last <= last_word && (nxt_idx == final_idx);
            end
        end
    end

endmodule

// File: rtl/cnn_host_ctrl.sv
// Host-side controller: packs the image byte stream into IF BRAM words, kicks
// the accelerator, then streams the TEMP result region back out byte by byte.
module cnn_host_ctrl
    import cnn_host_pkg::*;
#(
    parameter int unsigned       IMG_LEN  = 1024,
    parameter int unsigned       RES_LEN  = 294,
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] IF_BASE  = '0,
    parameter logic [ADDR_W-1:0] RES_BASE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              cnn_start,
    input  logic              cnn_done,
    output logic              busy,
    output logic [ADDR_W-1:0] BRAM_IF_ADDR,
    output logic [31:0]       BRAM_IF_DIN,
    output logic [3:0]        BRAM_IF_WE,
    output logic              BRAM_IF_EN,
    output logic [ADDR_W-1:0] BRAM_TEMP_ADDR,
    output logic [3:0]        BRAM_TEMP_WE,
    input  logic [31:0]       BRAM_TEMP_DOUT,
    output logic              BRAM_TEMP_EN
);

    localparam int IN_W       = $clog2(IMG_LEN + 1);
    localparam int RD_WORDS   = word_count(RES_LEN);
    localparam int RD_W       = $clog2(RD_WORDS + 1);
    localparam int LAST_BYTES = tail_bytes(RES_LEN);

    state_t            state;
    logic [IN_W-1:0]   in_cnt;
    logic [RD_W-1:0]   rd_word;
    logic [RD_W-1:0]   rd_word_nxt;
    logic [31:0]       pack_data;
    logic [31:0]       nxt_data;
    logic [3:0]        pack_we;
    logic [3:0]        nxt_we;
    logic [1:0]        lane;
    logic              accept;
    logic              last_byte;
    logic              word_full;
    logic              last_rd;
    logic              word_done;
    logic [ADDR_W-1:0] if_addr_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;

    assign lane        = in_cnt[1:0];
    assign accept      = in_valid && in_ready && (state == LOAD);
    assign last_byte   = (in_cnt == IN_W'(IMG_LEN - 1));
    assign word_full   = (lane == 2'd3) || last_byte;
    assign last_rd     = (rd_word == RD_W'(RD_WORDS - 1));
    assign rd_word_nxt = rd_word + RD_W'(1);
    assign if_addr_nxt = IF_BASE + (ADDR_W'(in_cnt >> 2) << 2);
    assign rd_addr_nxt = RES_BASE + (ADDR_W'(rd_word_nxt) << 2);

    assign BRAM_TEMP_WE = 4'b0000;

    // Current partial word with the incoming byte merged into its lane.
    always_comb begin
        nxt_data = pack_data;
        nxt_we   = pack_we;
        nxt_data[{lane, 3'b000} +: 8] = in_data;
        nxt_we[lane] = 1'b1;
    end

    // NOTE: strobes get a default of 0 at the top of the clocked block and are
    // raised by later non-blocking assignments, so each one lasts exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= LOAD;
            in_cnt         <= '0;
            rd_word        <= '0;
            pack_data      <= '0;
            pack_we        <= '0;
            in_ready       <= 1'b0;
            busy           <= 1'b0;
            cnn_start      <= 1'b0;
            BRAM_IF_ADDR   <= IF_BASE;
            BRAM_IF_DIN    <= '0;
            BRAM_IF_WE     <= '0;
            BRAM_IF_EN     <= 1'b0;
            BRAM_TEMP_ADDR <= RES_BASE;
            BRAM_TEMP_EN   <= 1'b0;
        end else begin
            BRAM_IF_EN   <= 1'b0;
            BRAM_IF_WE   <= '0;
            BRAM_TEMP_EN <= 1'b0;
            cnn_start    <= 1'b0;

            unique case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        busy   <= 1'b1;
                        in_cnt <= in_cnt + IN_W'(1);
                        if (word_full) begin
                            BRAM_IF_EN   <= 1'b1;
                            BRAM_IF_ADDR <= if_addr_nxt;
                            BRAM_IF_DIN  <= nxt_data;
                            BRAM_IF_WE   <= nxt_we;
                            pack_data    <= '0;
                            pack_we      <= '0;
                        end else begin
                            pack_data <= nxt_data;
                            pack_we   <= nxt_we;
                        end
                        if (last_byte) begin
                            in_ready <= 1'b0;
                            state    <= KICK;
                        end
                    end
                end
                KICK: begin
                    cnn_start <= 1'b1;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (cnn_done) begin
                        BRAM_TEMP_EN   <= 1'b1;
                        BRAM_TEMP_ADDR <= RES_BASE;
                        state          <= RD_REQ;
                    end
                end
                RD_REQ: state <= RD_CAP;
                RD_CAP: state <= EMIT;
                EMIT: begin
                    if (word_done) begin
                        if (last_rd) begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                            in_cnt   <= '0;
                            rd_word  <= '0;
                        end else begin
                            rd_word        <= rd_word_nxt;
                            BRAM_TEMP_EN   <= 1'b1;
                            BRAM_TEMP_ADDR <= rd_addr_nxt;
                            state          <= RD_REQ;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Read data arrives one cycle after the request, i.e. while in RD_CAP.
    cnn_host_unpack #(
        .LAST_BYTES(LAST_BYTES)
    ) u_unpack (
        .clk       (clk),
        .rst       (rst),
        .cap       (state == RD_CAP),
        .cap_last  (last_rd),
        .din       (BRAM_TEMP_DOUT),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .word_done (word_done)
    );

endmodule
